// File: rtl/idu_rename_pkg.sv
// Rename-stage constants and types shared by the free list and the rename table entries.
package idu_rename_pkg;

    localparam int unsigned PREG_NUM = 64;
    localparam int unsigned ARCH_NUM = 32;
    localparam int unsigned PREG_W   = $clog2(PREG_NUM);
    localparam int unsigned FL_DEPTH = PREG_NUM - ARCH_NUM;
    localparam int unsigned IDX_W    = $clog2(FL_DEPTH);
    localparam int unsigned PTR_W    = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [PTR_W-1:0]  ptr_t;

endpackage

// File: rtl/idu_ir_freelist_if.sv
// Handshake bundle between the rename stage / retire unit and the physical-register free list.
interface idu_ir_freelist_if;

    logic                   rtu_global_flush;
    logic                   y_idu_ir_stall_ctrl;
    logic                   ir_alloc_req;
    logic                   ir_alloc_vld;
    idu_rename_pkg::preg_t  ir_alloc_preg;
    logic                   rtu_retire_alloc_vld;
    logic                   rtu_release_vld;
    idu_rename_pkg::preg_t  rtu_release_preg;
    logic                   freelist_empty;
    idu_rename_pkg::ptr_t   freelist_cnt;

    modport master (
        output rtu_global_flush, y_idu_ir_stall_ctrl, ir_alloc_req,
               rtu_retire_alloc_vld, rtu_release_vld, rtu_release_preg,
        input  ir_alloc_vld, ir_alloc_preg, freelist_empty, freelist_cnt
    );

    modport slave (
        input  rtu_global_flush, y_idu_ir_stall_ctrl, ir_alloc_req,
               rtu_retire_alloc_vld, rtu_release_vld, rtu_release_preg,
        output ir_alloc_vld, ir_alloc_preg, freelist_empty, freelist_cnt
    );

endinterface

// File: rtl/idu_ir_freelist_ptr.sv
// Wrap-bit free-list pointer: load has priority over increment, wraps modulo 2**PTR_W.
module idu_ir_freelist_ptr
    import idu_rename_pkg::*;
#(
    parameter ptr_t RST_VAL = '0
) (
    input  logic clk,
    input  logic rst_clk,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t ptr
);

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            ptr <= RST_VAL;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/idu_ir_freelist.sv
// Physical-register free list: one grant per cycle from the alloc head, releases at the tail,
// and a commit pointer that lets a global flush reclaim all speculative grants at once.
module idu_ir_freelist
    import idu_rename_pkg::*;
(
    input  logic               clk,
    input  logic               rst_clk,
    idu_ir_freelist_if.slave   fl
);

    ptr_t  alloc_ptr;
    ptr_t  commit_ptr;
    ptr_t  tail_ptr;
    ptr_t  commit_nxt_c;
    ptr_t  occ_c;
    preg_t mem [FL_DEPTH];

    // Flush restores to the commit point including a retire landing this same cycle.
    assign commit_nxt_c = commit_ptr + PTR_W'(fl.rtu_retire_alloc_vld);
    assign occ_c        = tail_ptr - commit_ptr;

    assign fl.freelist_empty = (alloc_ptr == tail_ptr);
    assign fl.freelist_cnt   = tail_ptr - alloc_ptr;
    assign fl.ir_alloc_preg  = mem[alloc_ptr[IDX_W-1:0]];
    assign fl.ir_alloc_vld   = fl.ir_alloc_req & ~fl.freelist_empty
                             & ~fl.y_idu_ir_stall_ctrl & ~fl.rtu_global_flush;

    idu_ir_freelist_ptr #(.RST_VAL('0)) u_alloc_ptr (
        .clk      (clk),
        .rst_clk  (rst_clk),
        .inc      (fl.ir_alloc_vld),
        .load     (fl.rtu_global_flush),
        .load_val (commit_nxt_c),
        .ptr      (alloc_ptr)
    );

    idu_ir_freelist_ptr #(.RST_VAL('0)) u_commit_ptr (
        .clk      (clk),
        .rst_clk  (rst_clk),
        .inc      (fl.rtu_retire_alloc_vld),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (commit_ptr)
    );

    // Tail starts one full lap ahead: every non-architectural preg is free at reset.
    idu_ir_freelist_ptr #(.RST_VAL(ptr_t'(FL_DEPTH))) u_tail_ptr (
        .clk      (clk),
        .rst_clk  (rst_clk),
        .inc      (fl.rtu_release_vld),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (tail_ptr)
    );

    always_ff @(posedge clk or posedge rst_clk) begin
        if (rst_clk) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= preg_t'(ARCH_NUM + i);
            end
        end else if (fl.rtu_release_vld) begin
            mem[tail_ptr[IDX_W-1:0]] <= fl.rtu_release_preg;
        end
    end

    // A release not paired with a retire must never push the list past FL_DEPTH entries.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst_clk)
        (fl.rtu_release_vld && !fl.rtu_retire_alloc_vld) |-> (occ_c != ptr_t'(FL_DEPTH)));

    a_commit_behind_alloc: assert property (@(posedge clk) disable iff (rst_clk)
        fl.rtu_retire_alloc_vld |-> (commit_ptr != alloc_ptr));

endmodule

// File: tb/tb_idu_ir_freelist.sv
// Directed and randomized bench for idu_ir_freelist against a queue-based free-list model.
module tb_idu_ir_freelist;
    import idu_rename_pkg::*;

    logic clk     = 1'b0;
    logic rst_clk = 1'b0;
    always #5 clk = ~clk;

    idu_ir_freelist_if fl_if ();

    idu_ir_freelist dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .fl      (fl_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: free_q is the speculative free list in grant order, spec_q the granted-but-
    // uncommitted pregs in grant order, arch_q the committed mappings (stimulus only).
    int free_q[$];
    int spec_q[$];
    int arch_q[$];
    bit held[PREG_NUM];

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q = {};
        spec_q = {};
        arch_q = {};
        for (int i = 0; i < PREG_NUM; i++) held[i] = 1'b0;
        for (int i = 0; i < int'(FL_DEPTH); i++) free_q.push_back(int'(ARCH_NUM) + i);
        for (int i = 0; i < int'(ARCH_NUM); i++) begin
            arch_q.push_back(i);
            held[i] = 1'b1;
        end
    endtask

    task automatic drive_idle();
        fl_if.rtu_global_flush     = 1'b0;
        fl_if.y_idu_ir_stall_ctrl  = 1'b0;
        fl_if.ir_alloc_req         = 1'b0;
        fl_if.rtu_retire_alloc_vld = 1'b0;
        fl_if.rtu_release_vld      = 1'b0;
        fl_if.rtu_release_preg     = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_clk = 1'b0;
        model_reset();
        #1;
        check_val("rst_cnt",   fl_if.freelist_cnt,   32);
        check_val("rst_empty", fl_if.freelist_empty, 0);
        check_val("rst_preg",  fl_if.ir_alloc_preg,  32);
        check_val("rst_vld",   fl_if.ir_alloc_vld,   0);
    endtask

    // One cycle: drive, check comb outputs against the model, clock, advance the model.
    task automatic cycle(input bit flush, input bit stall, input bit req, input bit retire,
                         input bit rel, input int rel_p, output bit vld, output int preg);
        bit exp_vld;
        int p;
        fl_if.rtu_global_flush     = flush;
        fl_if.y_idu_ir_stall_ctrl  = stall;
        fl_if.ir_alloc_req         = req;
        fl_if.rtu_retire_alloc_vld = retire;
        fl_if.rtu_release_vld      = rel;
        fl_if.rtu_release_preg     = preg_t'(rel_p);
        #1;
        exp_vld = req && (free_q.size() > 0) && !stall && !flush;
        check_val("empty", fl_if.freelist_empty, (free_q.size() == 0) ? 1 : 0);
        check_val("cnt",   fl_if.freelist_cnt,   free_q.size());
        check_val("vld",   fl_if.ir_alloc_vld,   exp_vld ? 1 : 0);
        if (free_q.size() > 0) check_val("preg", fl_if.ir_alloc_preg, free_q[0]);
        if (fl_if.ir_alloc_vld === 1'b1) check_val("held", 32'(held[fl_if.ir_alloc_preg]), 0);
        vld  = fl_if.ir_alloc_vld;
        preg = int'(fl_if.ir_alloc_preg);
        @(posedge clk);
        if (exp_vld) begin
            p = free_q.pop_front();
            spec_q.push_back(p);
            held[p] = 1'b1;
        end
        if (retire && spec_q.size() > 0) void'(spec_q.pop_front());
        if (flush) begin
            foreach (spec_q[i]) held[spec_q[i]] = 1'b0;
            free_q = {spec_q, free_q};
            spec_q = {};
        end
        if (rel) begin
            free_q.push_back(rel_p);
            held[rel_p] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        bit v;
        int p;
        drive_idle();

        // Drain the whole reset list, then hit empty.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cycle(0, 0, 1, 0, 0, 0, v, p);
            check_val("t1_vld",  v, 1);
            check_val("t1_preg", p, 32 + i);
        end
        #1;
        check_val("t1_empty", fl_if.freelist_empty, 1);
        check_val("t1_cnt",   fl_if.freelist_cnt,   0);
        cycle(0, 0, 1, 0, 0, 0, v, p);
        check_val("t1_vld_empty", v, 0);

        // Release into an empty list: no bypass, allocatable next cycle.
        cycle(0, 0, 1, 1, 1, 7, v, p);
        check_val("t2_vld_c0", v, 0);
        cycle(0, 0, 1, 0, 0, 0, v, p);
        check_val("t2_vld_c1",  v, 1);
        check_val("t2_preg_c1", p, 7);

        // Flush rewinds alloc to commit.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0, 0, v, p);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, 0, v, p);
        cycle(1, 0, 0, 0, 0, 0, v, p);
        #1;
        check_val("t3_cnt",  fl_if.freelist_cnt,  30);
        check_val("t3_preg", fl_if.ir_alloc_preg, 34);
        cycle(0, 0, 1, 0, 0, 0, v, p);
        check_val("t3_grant", p, 34);

        // Flush with same-cycle retire and release.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, v, p);
        cycle(1, 0, 1, 1, 1, 9, v, p);
        check_val("t4_vld_flush", v, 0);
        #1;
        check_val("t4_cnt", fl_if.freelist_cnt, 32);
        for (int i = 0; i < 31; i++) begin
            cycle(0, 0, 1, 0, 0, 0, v, p);
            check_val("t4_preg", p, 33 + i);
        end
        cycle(0, 0, 1, 0, 0, 0, v, p);
        check_val("t4_tail9", p, 9);

        // Stall blocks grants but not releases.
        do_reset();
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0, 0, v, p);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 1, (k == 1), (k == 1), 5, v, p);
            check_val("t5_stall_vld", v, 0);
        end
        #1;
        check_val("t5_cnt", fl_if.freelist_cnt, 31);
        cycle(0, 0, 1, 0, 0, 0, v, p);
        check_val("t5_grant", p, 34);

        // Random traffic; each retire frees the old mapping of a committed register.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            bit fl_b, st_b, rq_b, rt_b;
            int rp;
            int idx;
            fl_b = ($urandom_range(0, 19) == 0);
            st_b = ($urandom_range(0, 6) == 0);
            rq_b = ($urandom_range(0, 9) < 7);
            rt_b = (spec_q.size() > 0) && ($urandom_range(0, 9) < 6);
            rp   = 0;
            if (rt_b) begin
                idx = int'($urandom_range(0, arch_q.size() - 1));
                rp  = arch_q[idx];
                arch_q.delete(idx);
                arch_q.push_back(spec_q[0]);
            end
            cycle(fl_b, st_b, rq_b, rt_b, rt_b, rp, v, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
